// File: rtl/adc_spi_ctrl.sv
// Serial ADC read sequencer: frames cs_n/sclk, strobes the external shifter
// during the data-bit window and latches the finished word into a held sample.
module adc_spi_ctrl #(
    parameter int ADC_WIDTH  = 8,
    parameter int FRAME_BITS = 16,
    parameter int LEAD_BITS  = 3,
    parameter int CLK_DIV    = 4,
    parameter int CS_SETUP   = 2,
    parameter int QUIET      = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [ADC_WIDTH-1:0] cur_vd,
    output logic                 cs_n,
    output logic                 sclk,
    output logic                 stp_en,
    output logic [ADC_WIDTH-1:0] sample,
    output logic                 sample_valid,
    output logic                 busy,
    output logic                 overrun
);

    localparam int IDX_W  = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;
    localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int SQ_MAX = (CS_SETUP > QUIET) ? CS_SETUP : QUIET;
    localparam int SQ_W   = (SQ_MAX > 1) ? $clog2(SQ_MAX) : 1;

    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(FRAME_BITS - 1);
    localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_PRE    = DIV_W'((CLK_DIV > 1) ? CLK_DIV - 2 : 0);
    localparam logic [SQ_W-1:0]  SETUP_LAST = SQ_W'(CS_SETUP - 1);
    localparam logic [SQ_W-1:0]  QUIET_LAST = SQ_W'((QUIET > 0) ? QUIET - 1 : 0);

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_SETUP    = 3'd1;
    localparam logic [2:0] ST_SHIFT_LO = 3'd2;
    localparam logic [2:0] ST_SHIFT_HI = 3'd3;
    localparam logic [2:0] ST_QUIET    = 3'd4;

    logic [2:0]       state;
    logic [IDX_W-1:0] bit_idx;
    logic [DIV_W-1:0] div_cnt;
    logic [SQ_W-1:0]  sq_cnt;

    function automatic logic in_window(input logic [IDX_W-1:0] idx);
        return (int'(idx) >= LEAD_BITS) && (int'(idx) < LEAD_BITS + ADC_WIDTH);
    endfunction

    // stp_en is registered, so it is raised one clock ahead of the sclk rise;
    // with CLK_DIV=1 that means on the very edge that enters SHIFT_LO.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            cs_n         <= 1'b1;
            sclk         <= 1'b1;
            stp_en       <= 1'b0;
            sample       <= '0;
            sample_valid <= 1'b0;
            busy         <= 1'b0;
            overrun      <= 1'b0;
            bit_idx      <= '0;
            div_cnt      <= '0;
            sq_cnt       <= '0;
        end else begin
            sample_valid <= 1'b0;
            overrun      <= start && (state != ST_IDLE);
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state  <= ST_SETUP;
                        cs_n   <= 1'b0;
                        busy   <= 1'b1;
                        sq_cnt <= '0;
                    end
                end
                ST_SETUP: begin
                    if (sq_cnt == SETUP_LAST) begin
                        state   <= ST_SHIFT_LO;
                        sclk    <= 1'b0;
                        div_cnt <= '0;
                        bit_idx <= '0;
                        stp_en  <= (CLK_DIV == 1) && in_window('0);
                    end else begin
                        sq_cnt <= sq_cnt + 1'b1;
                    end
                end
                ST_SHIFT_LO: begin
                    if (div_cnt == DIV_LAST) begin
                        state   <= ST_SHIFT_HI;
                        sclk    <= 1'b1;
                        div_cnt <= '0;
                        stp_en  <= 1'b0;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                        stp_en  <= (CLK_DIV > 1) && (div_cnt == DIV_PRE) && in_window(bit_idx);
                    end
                end
                ST_SHIFT_HI: begin
                    if (div_cnt != DIV_LAST) begin
                        div_cnt <= div_cnt + 1'b1;
                    end else if (bit_idx == LAST_IDX) begin
                        // A zero-length quiet gap skips QUIET so busy drops with cs_n.
                        cs_n         <= 1'b1;
                        sample       <= cur_vd;
                        sample_valid <= 1'b1;
                        sq_cnt       <= '0;
                        div_cnt      <= '0;
                        if (QUIET == 0) begin
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state <= ST_QUIET;
                        end
                    end else begin
                        state   <= ST_SHIFT_LO;
                        sclk    <= 1'b0;
                        div_cnt <= '0;
                        bit_idx <= bit_idx + 1'b1;
                        stp_en  <= (CLK_DIV == 1) && in_window(bit_idx + 1'b1);
                    end
                end
                ST_QUIET: begin
                    if (sq_cnt == QUIET_LAST) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        sq_cnt <= sq_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    cs_n  <= 1'b1;
                    sclk  <= 1'b1;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adc_spi_ctrl.sv
// Directed bench for adc_spi_ctrl: default instance plus a fast-corner instance,
// each fed by a small ADC/shifter model.
module tb_adc_spi_ctrl;

    logic       clk;
    logic       clk_en;
    logic       rst;

    logic       d_start, d_cs_n, d_sclk, d_stp_en, d_sample_valid, d_busy, d_overrun;
    logic [7:0] d_cur_vd, d_sample;
    logic       c_start, c_cs_n, c_sclk, c_stp_en, c_sample_valid, c_busy, c_overrun;
    logic [7:0] c_cur_vd, c_sample;

    adc_spi_ctrl dut (
        .clk(clk), .rst(rst), .start(d_start), .cur_vd(d_cur_vd),
        .cs_n(d_cs_n), .sclk(d_sclk), .stp_en(d_stp_en), .sample(d_sample),
        .sample_valid(d_sample_valid), .busy(d_busy), .overrun(d_overrun)
    );

    adc_spi_ctrl #(
        .ADC_WIDTH(8), .FRAME_BITS(8), .LEAD_BITS(0),
        .CLK_DIV(1), .CS_SETUP(1), .QUIET(0)
    ) dut_corner (
        .clk(clk), .rst(rst), .start(c_start), .cur_vd(c_cur_vd),
        .cs_n(c_cs_n), .sclk(c_sclk), .stp_en(c_stp_en), .sample(c_sample),
        .sample_valid(c_sample_valid), .busy(c_busy), .overrun(c_overrun)
    );

    initial begin
        clk = 1'b0;
        wait (clk_en);
        forever #5 clk = ~clk;
    end

    int tests_run = 0;
    int tests_failed = 0;
    int cyc = 0;
    int e0 = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // ADC model: one frame word per cs_n fall, bit n presented until the n-th sclk rise
    logic [7:0]  adc_data [0:7];
    int          adc_ptr = 0;
    logic [15:0] d_frame = '0;
    logic [7:0]  c_frame = '0;
    int          d_rises = 0;
    int          c_rises = 0;
    logic        d_cs_prev = 1'b1, d_sclk_prev = 1'b1;
    logic        c_cs_prev = 1'b1, c_sclk_prev = 1'b1;
    logic        d_din, c_din;
    logic [7:0]  d_shreg, c_shreg;

    assign d_din = (d_rises < 16) ? d_frame[15 - d_rises] : 1'b0;
    assign c_din = (c_rises < 8) ? c_frame[7 - c_rises] : 1'b0;
    assign d_cur_vd = d_shreg;
    assign c_cur_vd = c_shreg;

    always begin
        @(posedge clk);
        #1;
        if (d_cs_prev && !d_cs_n) begin
            d_frame = {3'b000, adc_data[adc_ptr], 5'b00000};
            adc_ptr = adc_ptr + 1;
            d_rises = 0;
        end else if (!d_sclk_prev && d_sclk) begin
            d_rises = d_rises + 1;
        end
        if (c_cs_prev && !c_cs_n) begin
            c_frame = adc_data[0];
            c_rises = 0;
        end else if (!c_sclk_prev && c_sclk) begin
            c_rises = c_rises + 1;
        end
        d_cs_prev = d_cs_n;
        d_sclk_prev = d_sclk;
        c_cs_prev = c_cs_n;
        c_sclk_prev = c_sclk;
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            d_shreg <= '0;
            c_shreg <= '0;
        end else begin
            if (d_stp_en) d_shreg <= {d_shreg[6:0], d_din};
            if (c_stp_en) c_shreg <= {c_shreg[6:0], c_din};
        end
    end

    // Event log, edge numbers relative to e0
    int         stp_times[$];
    int         sv_times[$];
    logic [7:0] sv_vals[$];
    int         c_stp_times[$];

    always begin
        @(posedge clk);
        #2;
        if (d_stp_en) stp_times.push_back(cyc + 1 - e0);
        if (d_sample_valid) begin
            sv_times.push_back(cyc - e0);
            sv_vals.push_back(d_sample);
        end
        if (c_stp_en) c_stp_times.push_back(cyc + 1 - e0);
    end

    initial begin
        #1ms;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic clearLogs();
        stp_times.delete();
        sv_times.delete();
        sv_vals.delete();
        c_stp_times.delete();
    endtask

    task automatic waitEdge(input int n);
        while (cyc < e0 + n) @(negedge clk);
    endtask

    // One-clock start pulse on the default instance carrying a single data word
    task automatic applyStimulus(input logic [7:0] data);
        adc_data[0] = data;
        adc_ptr = 0;
        clearLogs();
        d_start = 1'b1;
        e0 = cyc + 1;
        @(negedge clk);
        d_start = 1'b0;
    endtask

    initial begin
        clk_en = 1'b0;
        rst = 1'b1;
        d_start = 1'b0;
        c_start = 1'b0;
        for (int i = 0; i < 8; i++) adc_data[i] = '0;

        #1;
        checkOutput("rst cs_n", {31'd0, d_cs_n}, 32'd1);
        checkOutput("rst sclk", {31'd0, d_sclk}, 32'd1);
        checkOutput("rst stp_en", {31'd0, d_stp_en}, 32'd0);
        checkOutput("rst sample", {24'd0, d_sample}, 32'd0);
        checkOutput("rst sample_valid", {31'd0, d_sample_valid}, 32'd0);
        checkOutput("rst busy", {31'd0, d_busy}, 32'd0);
        checkOutput("rst overrun", {31'd0, d_overrun}, 32'd0);
        checkOutput("rst corner cs_n", {31'd0, c_cs_n}, 32'd1);

        #3 rst = 1'b0;
        clk_en = 1'b1;
        repeat (3) @(negedge clk);

        // Single conversion of 0xB3
        applyStimulus(8'hB3);
        waitEdge(1);
        checkOutput("single sclk before first fall", {31'd0, d_sclk}, 32'd1);
        waitEdge(2);
        checkOutput("single first sclk fall", {31'd0, d_sclk}, 32'd0);
        waitEdge(129);
        checkOutput("single cs_n low at 129", {31'd0, d_cs_n}, 32'd0);
        waitEdge(130);
        checkOutput("single cs_n high at 130", {31'd0, d_cs_n}, 32'd1);
        checkOutput("single sample_valid at 130", {31'd0, d_sample_valid}, 32'd1);
        checkOutput("single sample", {24'd0, d_sample}, 32'hB3);
        waitEdge(133);
        checkOutput("single busy at 133", {31'd0, d_busy}, 32'd1);
        waitEdge(134);
        checkOutput("single busy at 134", {31'd0, d_busy}, 32'd0);
        checkOutput("single sclk rises", d_rises, 32'd16);
        checkOutput("single stp count", stp_times.size(), 32'd8);
        for (int i = 0; i < 8; i++)
            checkOutput($sformatf("single stp edge %0d", i), stp_times[i], 30 + 8 * i);
        checkOutput("single sv count", sv_times.size(), 32'd1);
        checkOutput("single sv edge", sv_times[0], 32'd130);

        // Back-to-back frames with start held high
        repeat (3) @(negedge clk);
        adc_data[0] = 8'h00;
        adc_data[1] = 8'hFF;
        adc_data[2] = 8'h5A;
        adc_ptr = 0;
        clearLogs();
        d_start = 1'b1;
        e0 = cyc + 1;
        waitEdge(129);
        checkOutput("b2b cs_n low at 129", {31'd0, d_cs_n}, 32'd0);
        waitEdge(130);
        checkOutput("b2b cs_n high at 130", {31'd0, d_cs_n}, 32'd1);
        waitEdge(134);
        checkOutput("b2b cs_n high at 134", {31'd0, d_cs_n}, 32'd1);
        waitEdge(135);
        checkOutput("b2b cs_n low at 135", {31'd0, d_cs_n}, 32'd0);
        waitEdge(270);
        d_start = 1'b0;
        waitEdge(420);
        checkOutput("b2b sv count", sv_times.size(), 32'd3);
        checkOutput("b2b sv edge 0", sv_times[0], 32'd130);
        checkOutput("b2b sv edge 1", sv_times[1], 32'd265);
        checkOutput("b2b sv edge 2", sv_times[2], 32'd400);
        checkOutput("b2b sample 0", {24'd0, sv_vals[0]}, 32'h00);
        checkOutput("b2b sample 1", {24'd0, sv_vals[1]}, 32'hFF);
        checkOutput("b2b sample 2", {24'd0, sv_vals[2]}, 32'h5A);
        checkOutput("b2b idle after", {31'd0, d_busy}, 32'd0);

        // Overrun: extra starts during the frame and in the quiet gap
        applyStimulus(8'h3C);
        waitEdge(49);
        d_start = 1'b1;
        waitEdge(50);
        d_start = 1'b0;
        checkOutput("overrun at 50", {31'd0, d_overrun}, 32'd1);
        waitEdge(51);
        checkOutput("overrun clear at 51", {31'd0, d_overrun}, 32'd0);
        waitEdge(131);
        d_start = 1'b1;
        waitEdge(132);
        d_start = 1'b0;
        checkOutput("overrun at 132", {31'd0, d_overrun}, 32'd1);
        checkOutput("overrun busy at 132", {31'd0, d_busy}, 32'd1);
        waitEdge(140);
        checkOutput("overrun idle at 140", {31'd0, d_busy}, 32'd0);
        checkOutput("overrun cs_n at 140", {31'd0, d_cs_n}, 32'd1);
        checkOutput("overrun sv count", sv_times.size(), 32'd1);
        checkOutput("overrun sv edge", sv_times[0], 32'd130);
        checkOutput("overrun sample", {24'd0, d_sample}, 32'h3C);
        checkOutput("overrun stp count", stp_times.size(), 32'd8);
        checkOutput("overrun stp first", stp_times[0], 32'd30);
        checkOutput("overrun stp last", stp_times[7], 32'd86);

        // Reset in the middle of a data-bit strobe
        applyStimulus(8'h77);
        waitEdge(61);
        checkOutput("midrst pre stp_en", {31'd0, d_stp_en}, 32'd1);
        checkOutput("midrst pre sclk", {31'd0, d_sclk}, 32'd0);
        checkOutput("midrst pre cs_n", {31'd0, d_cs_n}, 32'd0);
        #1 rst = 1'b1;
        #1;
        checkOutput("midrst cs_n", {31'd0, d_cs_n}, 32'd1);
        checkOutput("midrst sclk", {31'd0, d_sclk}, 32'd1);
        checkOutput("midrst stp_en", {31'd0, d_stp_en}, 32'd0);
        checkOutput("midrst sample", {24'd0, d_sample}, 32'd0);
        checkOutput("midrst busy", {31'd0, d_busy}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        checkOutput("midrst no sample_valid", sv_times.size(), 32'd0);
        applyStimulus(8'hC5);
        waitEdge(140);
        checkOutput("postrst sample", {24'd0, d_sample}, 32'hC5);
        checkOutput("postrst sv count", sv_times.size(), 32'd1);
        checkOutput("postrst sv edge", sv_times[0], 32'd130);
        checkOutput("postrst stp count", stp_times.size(), 32'd8);
        checkOutput("postrst sclk rises", d_rises, 32'd16);

        // Fast corner instance: CLK_DIV=1, no lead bits, no quiet gap
        adc_data[0] = 8'h81;
        clearLogs();
        c_start = 1'b1;
        e0 = cyc + 1;
        @(negedge clk);
        c_start = 1'b0;
        waitEdge(16);
        checkOutput("corner cs_n at 16", {31'd0, c_cs_n}, 32'd0);
        checkOutput("corner busy at 16", {31'd0, c_busy}, 32'd1);
        waitEdge(17);
        checkOutput("corner sample", {24'd0, c_sample}, 32'h81);
        checkOutput("corner sample_valid", {31'd0, c_sample_valid}, 32'd1);
        checkOutput("corner busy at 17", {31'd0, c_busy}, 32'd0);
        checkOutput("corner cs_n at 17", {31'd0, c_cs_n}, 32'd1);
        checkOutput("corner stp count", c_stp_times.size(), 32'd8);
        for (int i = 0; i < 8; i++)
            checkOutput($sformatf("corner stp edge %0d", i), c_stp_times[i], 2 + 2 * i);

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
